// File: rtl/pwm_burst_gen.sv
// PWM generator with burst/continuous modes and shadowed configuration.
// Starts from a software strobe or a synchronised external start pin.
module pwm_burst_gen #(
    parameter int WIDTH       = 8,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_duty,
    input  logic [CNT_W-1:0] cfg_pulses,
    input  logic             cfg_enable,
    input  logic             cfg_wr,
    input  logic             sw_start,
    input  logic             start_ext,
    output logic             pwm,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] cnt
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q;
    logic                   ext_rise;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] per_q, per_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [CNT_W-1:0] pulses_q, pulses_d;
    logic [WIDTH-1:0] pend_per_q, pend_per_d;
    logic [WIDTH-1:0] pend_duty_q, pend_duty_d;
    logic [CNT_W-1:0] pend_pulses_q, pend_pulses_d;
    logic             done_q, done_d;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], start_ext};
    assign ext_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    // Synchroniser and edge detector run regardless of ena.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Core state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rem_q         <= '0;
            per_q         <= '0;
            duty_q        <= '0;
            pulses_q      <= '0;
            pend_per_q    <= '0;
            pend_duty_q   <= '0;
            pend_pulses_q <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            per_q         <= per_d;
            duty_q        <= duty_d;
            pulses_q      <= pulses_d;
            pend_per_q    <= pend_per_d;
            pend_duty_q   <= pend_duty_d;
            pend_pulses_q <= pend_pulses_d;
            done_q        <= done_d;
        end
    end

    // Next-state: start, period counting, boundary reload, burst end.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        per_d         = per_q;
        duty_d        = duty_q;
        pulses_d      = pulses_q;
        pend_per_d    = pend_per_q;
        pend_duty_d   = pend_duty_q;
        pend_pulses_d = pend_pulses_q;
        done_d        = 1'b0;
        if (ena) begin
            if (cfg_wr) begin
                pend_per_d    = cfg_period;
                pend_duty_d   = cfg_duty;
                pend_pulses_d = cfg_pulses;
            end
            unique case (state_q)
                IDLE: begin
                    if (cfg_enable && (sw_start || ext_rise)) begin
                        state_d  = RUN;
                        cnt_d    = '0;
                        per_d    = pend_per_q;
                        duty_d   = pend_duty_q;
                        pulses_d = pend_pulses_q;
                        rem_d    = pend_pulses_q;
                    end
                end
                RUN: begin
                    if (!cfg_enable) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == per_q) begin
                        cnt_d    = '0;
                        per_d    = cfg_wr ? cfg_period : pend_per_q;
                        duty_d   = cfg_wr ? cfg_duty   : pend_duty_q;
                        pulses_d = cfg_wr ? cfg_pulses : pend_pulses_q;
                        if (pulses_q != '0) begin
                            if (rem_q == CNT_W'(1)) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end
                            if (rem_q != '0) begin
                                rem_d = rem_q - 1'b1;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign pwm  = (state_q == RUN) && (cnt_q < duty_q);
    assign busy = (state_q == RUN);
    assign done = done_q;
    assign cnt  = cnt_q;

endmodule

// File: tb/tb_pwm_burst_gen.sv
// Self-checking bench for pwm_burst_gen.
// Expected outputs come from an arithmetic model of period/duty/burst.
module tb_pwm_burst_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] cfg_period;
    logic [7:0] cfg_duty;
    logic [7:0] cfg_pulses;
    logic       cfg_enable;
    logic       cfg_wr;
    logic       sw_start;
    logic       start_ext;
    logic       pwm;
    logic       busy;
    logic       done;
    logic [7:0] cnt;

    int nchk  = 0;
    int nfail = 0;

    logic [10:0] obs;
    logic [10:0] expv;

    assign obs = {busy, done, pwm, cnt};

    pwm_burst_gen #(
        .WIDTH(8),
        .CNT_W(8),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .cfg_period(cfg_period),
        .cfg_duty(cfg_duty),
        .cfg_pulses(cfg_pulses),
        .cfg_enable(cfg_enable),
        .cfg_wr(cfg_wr),
        .sw_start(sw_start),
        .start_ext(start_ext),
        .pwm(pwm),
        .busy(busy),
        .done(done),
        .cnt(cnt)
    );

    always #5 clk = ~clk;

    // Expected {busy,done,pwm,cnt} after e enabled cycles of a run.
    function automatic logic [10:0] mexp(int p, int d, int n, int e,
                                         bit dn);
        int pos;
        if (n != 0 && e >= (p + 1) * n)
            return {1'b0, dn, 1'b0, 8'd0};
        pos = e % (p + 1);
        return {1'b1, 1'b0, pos < d, 8'(pos)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(int p, int d, int n);
        cfg_period = 8'(p);
        cfg_duty   = 8'(d);
        cfg_pulses = 8'(n);
        cfg_wr     = 1'b1;
        step();
        cfg_wr = 1'b0;
    endtask

    task automatic start_sw();
        sw_start = 1'b1;
        step();
        sw_start = 1'b0;
    endtask

    task automatic abort_run();
        cfg_enable = 1'b0;
        step();
        cfg_enable = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        expv = 11'd0;
        nchk++;
        if (obs !== expv) begin
            nfail++;
            $display("FAIL reset got=%h exp=%h", obs, expv);
        end
    endtask

    task automatic run_burst(int p, int d, int n, string name);
        int len;
        write_cfg(p, d, n);
        start_sw();
        len = (p + 1) * n;
        for (int t = 0; t <= len + 1; t++) begin
            expv = mexp(p, d, n, t, t == len);
            nchk++;
            if (obs !== expv) begin
                nfail++;
                $display("FAIL %s t=%0d got=%h exp=%h",
                         name, t, obs, expv);
            end
            step();
        end
    endtask

    task automatic test_continuous();
        write_cfg(9, 3, 0);
        start_sw();
        for (int t = 0; t < 40; t++) begin
            expv = mexp(9, 3, 0, t, 1'b0);
            nchk++;
            if (obs !== expv) begin
                nfail++;
                $display("FAIL continuous t=%0d got=%h exp=%h",
                         t, obs, expv);
            end
            sw_start = (t == 15);
            step();
        end
        sw_start = 1'b0;
        abort_run();
    endtask

    task automatic test_burst();
        run_burst(9, 3, 2, "burst");
    endtask

    task automatic test_ext_start();
        write_cfg(9, 3, 0);
        step();
        #3 start_ext = 1'b1;
        step();
        expv = 11'd0;
        nchk++;
        if (obs !== expv) begin
            nfail++;
            $display("FAIL ext_k got=%h exp=%h", obs, expv);
        end
        step();
        nchk++;
        if (obs !== expv) begin
            nfail++;
            $display("FAIL ext_k1 got=%h exp=%h", obs, expv);
        end
        step();
        for (int t = 0; t < 16; t++) begin
            expv = mexp(9, 3, 0, t, 1'b0);
            nchk++;
            if (obs !== expv) begin
                nfail++;
                $display("FAIL ext_run t=%0d got=%h exp=%h",
                         t, obs, expv);
            end
            if (t == 1) start_ext = 1'b0;
            if (t == 4) start_ext = 1'b1;
            if (t == 8) start_ext = 1'b0;
            step();
        end
        step();
        step();
        abort_run();
        expv = 11'd0;
        for (int t = 0; t < 5; t++) begin
            #1 start_ext = 1'b1;
            #2 start_ext = 1'b0;
            step();
            nchk++;
            if (obs !== expv) begin
                nfail++;
                $display("FAIL ext_glitch t=%0d got=%h exp=%h",
                         t, obs, expv);
            end
        end
    endtask

    task automatic test_boundaries();
        run_burst(9, 0, 2, "duty_zero");
        run_burst(9, 12, 2, "duty_over");
        run_burst(0, 1, 3, "period_zero");
    endtask

    task automatic test_shadow();
        int d;
        write_cfg(9, 3, 0);
        start_sw();
        for (int t = 0; t < 30; t++) begin
            d = (t < 10) ? 3 : (t < 20) ? 7 : 2;
            expv = mexp(9, d, 0, t, 1'b0);
            nchk++;
            if (obs !== expv) begin
                nfail++;
                $display("FAIL shadow t=%0d got=%h exp=%h",
                         t, obs, expv);
            end
            cfg_period = 8'd9;
            cfg_pulses = 8'd0;
            cfg_duty   = (t == 4) ? 8'd7 : 8'd2;
            cfg_wr     = (t == 4) || (t == 19);
            step();
            cfg_wr = 1'b0;
        end
        abort_run();
    endtask

    task automatic test_abort();
        write_cfg(9, 3, 2);
        start_sw();
        repeat (5) step();
        expv = {1'b1, 1'b0, 1'b0, 8'd5};
        nchk++;
        if (obs !== expv) begin
            nfail++;
            $display("FAIL abort_pre got=%h exp=%h", obs, expv);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        expv = 11'd0;
        nchk++;
        if (obs !== expv) begin
            nfail++;
            $display("FAIL abort_rst got=%h exp=%h", obs, expv);
        end
        step();
        nchk++;
        if (obs !== expv) begin
            nfail++;
            $display("FAIL abort_rst2 got=%h exp=%h", obs, expv);
        end
        write_cfg(9, 3, 2);
        start_sw();
        repeat (5) step();
        cfg_enable = 1'b0;
        step();
        cfg_enable = 1'b1;
        nchk++;
        if (obs !== expv) begin
            nfail++;
            $display("FAIL abort_en got=%h exp=%h", obs, expv);
        end
        step();
        nchk++;
        if (obs !== expv) begin
            nfail++;
            $display("FAIL abort_en2 got=%h exp=%h", obs, expv);
        end
    endtask

    task automatic test_ena_freeze();
        int raw;
        write_cfg(9, 3, 1);
        start_sw();
        step();
        step();
        raw = 2;
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sw_start = 1'b1;
            step();
            raw++;
            expv = mexp(9, 3, 1, 2, 1'b0);
            nchk++;
            if (obs !== expv) begin
                nfail++;
                $display("FAIL freeze i=%0d got=%h exp=%h",
                         i, obs, expv);
            end
        end
        sw_start = 1'b0;
        ena = 1'b1;
        for (int e = 3; e <= 10; e++) begin
            step();
            raw++;
            expv = mexp(9, 3, 1, e, e == 10);
            nchk++;
            if (obs !== expv) begin
                nfail++;
                $display("FAIL freeze_run e=%0d got=%h exp=%h",
                         e, obs, expv);
            end
        end
        nchk++;
        if (raw !== 15) begin
            nfail++;
            $display("FAIL freeze_len got=%0d exp=15", raw);
        end
    endtask

    task automatic test_random();
        int  p, d, n, len, e;
        bit  en, dn, fin;
        for (int k = 0; k < 12; k++) begin
            p = $urandom_range(0, 15);
            d = $urandom_range(0, 20);
            n = $urandom_range(1, 4);
            len = (p + 1) * n;
            write_cfg(p, d, n);
            start_sw();
            e = 0;
            fin = 1'b0;
            for (int i = 0; i < 500 && !fin; i++) begin
                en = ($urandom_range(0, 3) != 0);
                ena = en;
                step();
                dn = 1'b0;
                if (en && e < len) begin
                    e++;
                    dn = (e == len);
                end
                expv = mexp(p, d, n, e, dn);
                nchk++;
                if (obs !== expv) begin
                    nfail++;
                    $display("FAIL rand k=%0d e=%0d got=%h exp=%h",
                             k, e, obs, expv);
                end
                if (e == len && !dn) fin = 1'b1;
            end
            ena = 1'b1;
            nchk++;
            if (!fin) begin
                nfail++;
                $display("FAIL rand_timeout k=%0d got=%0d exp=%0d",
                         k, e, len);
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        ena        = 1'b1;
        cfg_period = 8'd0;
        cfg_duty   = 8'd0;
        cfg_pulses = 8'd0;
        cfg_enable = 1'b1;
        cfg_wr     = 1'b0;
        sw_start   = 1'b0;
        start_ext  = 1'b0;
        test_reset();
        test_continuous();
        test_burst();
        test_ext_start();
        test_boundaries();
        test_shadow();
        test_abort();
        test_ena_freeze();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule
